// File: rtl/fifo_write_arbiter.sv
// Frame-atomic round-robin arbiter sharing one message FIFO write port among NUM_REQ controllers.
// Optional idle-owner watchdog enabled by defining ARB_TIMEOUT_EN.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          wr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    input  logic [NUM_REQ-1:0]          last_i,
    input  logic                        full_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [NUM_REQ-1:0]          ready_o,
    output logic                        fifo_wr_o,
    output logic [DATA_W-1:0]           fifo_data_o,
    output logic                        timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [PTR_W-1:0]     ptr_reg, ptr_next;
    logic                 timeout_pulse;

    logic [PTR_W-1:0]     owner_idx;
    logic [PTR_W-1:0]     owner_ptr_next;
    logic [PTR_W-1:0]     hi_idx, lo_idx, sel_idx;
    logic                 found_hi, found_lo;
    logic                 accepted;
    logic [DATA_W-1:0]    lane_masked [NUM_REQ];
    logic [DATA_W-1:0]    fifo_data_comb;

`ifdef ARB_TIMEOUT_EN
    logic [15:0]          wdog_reg, wdog_next;
`else
    logic                 unused_timeout_lim;
    assign unused_timeout_lim = ^TIMEOUT_LIM;
`endif

    // Round-robin pick: lowest set request at or above the pointer, else wrap to the lowest below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                if (i >= int'(ptr_reg)) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        hi_idx   = PTR_W'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_idx   = PTR_W'(i);
                end
            end
        end
        sel_idx = found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_reg[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign owner_ptr_next = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    assign accepted       = (state_reg == ST_GRANT) & wr_i[owner_idx] & ~full_i;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        timeout_pulse = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wdog_next     = wdog_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|req_i) begin
                    grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    state_next = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    wdog_next  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (accepted) begin
`ifdef ARB_TIMEOUT_EN
                    wdog_next = '0;
`endif
                    if (last_i[owner_idx]) begin
                        grant_next = '0;
                        ptr_next   = owner_ptr_next;
                        state_next = ST_IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // Full cycles freeze the count; the owner is only blamed for idle cycles it could have used.
                else if (wdog_reg >= TIMEOUT_LIM) begin
                    timeout_pulse = 1'b1;
                    grant_next    = '0;
                    ptr_next      = owner_ptr_next;
                    state_next    = ST_IDLE;
                end else if (!full_i) begin
                    wdog_next = wdog_reg + 16'd1;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
`ifdef ARB_TIMEOUT_EN
            wdog_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
`ifdef ARB_TIMEOUT_EN
            wdog_reg  <= wdog_next;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_masked[gi] = grant_reg[gi] ? data_i[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        fifo_data_comb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_data_comb = fifo_data_comb | lane_masked[i];
        end
    end

    assign grant_o     = grant_reg;
    assign ready_o     = grant_reg & {NUM_REQ{~full_i}};
    assign fifo_wr_o   = (|(wr_i & grant_reg)) & ~full_i;
    assign fifo_data_o = fifo_data_comb;
`ifdef ARB_TIMEOUT_EN
    assign timeout_o   = timeout_pulse;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (4 requesters, 8-bit lanes).
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    wr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    last;
    logic            full;
    logic [N-1:0]    grant;
    logic [N-1:0]    ready;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_data;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .wr_i        (wr),
        .data_i      (data),
        .last_i      (last),
        .full_i      (full),
        .grant_o     (grant),
        .ready_o     (ready),
        .fifo_wr_o   (fifo_wr),
        .fifo_data_o (fifo_data),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge; inputs for the new cycle are then driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req  = '0;
        wr   = '0;
        last = '0;
        full = 1'b0;
        data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        settle();
        check_eq("reset grant", 32'(grant), 32'h0);
        check_eq("reset fifo_wr", 32'(fifo_wr), 32'h0);
        check_eq("reset timeout", 32'(timeout), 32'h0);
        check_eq("reset ready", 32'(ready), 32'h0);
        rst = 1'b0;

        // 1: single requester, three-byte frame
        tick();
        req = 4'b0001;
        settle();
        check_eq("t1 grant before", 32'(grant), 32'h0);
        tick();
        wr = 4'b0001; data[7:0] = 8'h11;
        settle();
        check_eq("t1 grant", 32'(grant), 32'h1);
        check_eq("t1 b0 wr", 32'(fifo_wr), 32'h1);
        check_eq("t1 b0 data", 32'(fifo_data), 32'h11);
        tick();
        req = 4'b0000; data[7:0] = 8'h22;
        settle();
        check_eq("t1 b1 wr", 32'(fifo_wr), 32'h1);
        check_eq("t1 b1 data", 32'(fifo_data), 32'h22);
        tick();
        data[7:0] = 8'h33; last = 4'b0001;
        settle();
        check_eq("t1 b2 wr", 32'(fifo_wr), 32'h1);
        check_eq("t1 b2 data", 32'(fifo_data), 32'h33);
        tick();
        wr = '0; last = '0;
        settle();
        check_eq("t1 grant released", 32'(grant), 32'h0);
        check_eq("t1 no 4th write", 32'(fifo_wr), 32'h0);
        tick();
        settle();
        check_eq("t1 grant still 0", 32'(grant), 32'h0);

        // 2: all requesting, two-byte frames, round-robin order
        do_reset();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            int k;
            k = f % N;
            wr = 4'b1111; last = '0;
            for (int l = 0; l < N; l++) data[l*DW +: DW] = 8'hA0 | 8'(l);
            settle();
            check_eq($sformatf("t2 f%0d idle grant", f), 32'(grant), 32'h0);
            check_eq($sformatf("t2 f%0d idle no wr", f), 32'(fifo_wr), 32'h0);
            tick();
            settle();
            check_eq($sformatf("t2 f%0d grant", f), 32'(grant), 32'(1 << k));
            check_eq($sformatf("t2 f%0d b0", f), 32'(fifo_data), 32'hA0 | 32'(k));
            check_eq($sformatf("t2 f%0d b0 wr", f), 32'(fifo_wr), 32'h1);
            tick();
            last = 4'b1111;
            for (int l = 0; l < N; l++) data[l*DW +: DW] = 8'hB0 | 8'(l);
            settle();
            check_eq($sformatf("t2 f%0d hold grant", f), 32'(grant), 32'(1 << k));
            check_eq($sformatf("t2 f%0d b1", f), 32'(fifo_data), 32'hB0 | 32'(k));
            tick();
        end
        idle_inputs();

        // 3: back-pressure on owner 2
        do_reset();
        req = 4'b0100;
        tick();
        wr = 4'b0100; data[2*DW +: DW] = 8'h21;
        settle();
        check_eq("t3 grant", 32'(grant), 32'h4);
        check_eq("t3 b0 data", 32'(fifo_data), 32'h21);
        tick();
        full = 1'b1; data[2*DW +: DW] = 8'h22;
        for (int c = 0; c < 5; c++) begin
            settle();
            check_eq($sformatf("t3 full%0d wr", c), 32'(fifo_wr), 32'h0);
            check_eq($sformatf("t3 full%0d ready", c), 32'(ready), 32'h0);
            check_eq($sformatf("t3 full%0d grant", c), 32'(grant), 32'h4);
            tick();
        end
        full = 1'b0;
        settle();
        check_eq("t3 release wr", 32'(fifo_wr), 32'h1);
        check_eq("t3 release data", 32'(fifo_data), 32'h22);
        check_eq("t3 release ready", 32'(ready), 32'h4);
        tick();
        data[2*DW +: DW] = 8'h23; last = 4'b0100; req = '0;
        settle();
        check_eq("t3 last data", 32'(fifo_data), 32'h23);
        tick();
        idle_inputs();
        settle();
        check_eq("t3 grant released", 32'(grant), 32'h0);

        // 4: non-owner writes ignored
        do_reset();
        req = 4'b0001;
        tick();
        wr = 4'b1000; data[3*DW +: DW] = 8'hAA; data[7:0] = 8'h55;
        settle();
        check_eq("t4 stray wr", 32'(fifo_wr), 32'h0);
        check_eq("t4 owner lane", 32'(fifo_data), 32'h55);
        check_eq("t4 ready", 32'(ready), 32'h1);
        tick();
        wr = 4'b1001; data[7:0] = 8'h56; last = 4'b0001; req = '0;
        settle();
        check_eq("t4 owner wr", 32'(fifo_wr), 32'h1);
        check_eq("t4 owner data", 32'(fifo_data), 32'h56);
        tick();
        idle_inputs();

        // 5: reset mid-frame from owner 1
        do_reset();
        req = 4'b0010;
        tick();
        wr = 4'b0010; data[DW +: DW] = 8'h41;
        settle();
        check_eq("t5 grant", 32'(grant), 32'h2);
        tick();
        data[DW +: DW] = 8'h42; rst = 1'b1;
        tick();
        settle();
        check_eq("t5 grant dropped", 32'(grant), 32'h0);
        check_eq("t5 no wr in reset", 32'(fifo_wr), 32'h0);
        rst = 1'b0; wr = '0; req = 4'b1010;
        settle();
        check_eq("t5 idle after rst", 32'(grant), 32'h0);
        tick();
        req = '0;
        settle();
        check_eq("t5 rewin ptr0", 32'(grant), 32'h2);

`ifdef ARB_TIMEOUT_EN
        // 6: watchdog revokes an idle owner
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0110;
        for (int c = 0; c < 8; c++) begin
            settle();
            check_eq($sformatf("t6 c%0d timeout", c), 32'(timeout), 32'h0);
            check_eq($sformatf("t6 c%0d grant", c), 32'(grant), 32'h2);
            tick();
        end
        settle();
        check_eq("t6 timeout pulse", 32'(timeout), 32'h1);
        tick();
        settle();
        check_eq("t6 pulse ends", 32'(timeout), 32'h0);
        check_eq("t6 revoked", 32'(grant), 32'h0);
        tick();
        settle();
        check_eq("t6 req2 granted", 32'(grant), 32'h4);
`else
        // 6: without the watchdog an idle owner keeps its grant
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0110;
        for (int c = 0; c < 20; c++) tick();
        settle();
        check_eq("t6 no timeout", 32'(timeout), 32'h0);
        check_eq("t6 grant held", 32'(grant), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
